// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: ID-side forwarding selects, load-use stall, MUL freeze and bypassed NZVC flags
module pipe_hazard_unit #(
  parameter int NREG = 32,
  parameter int REG_W = $clog2(NREG),
  parameter int FWD_STAGES = 3,
  parameter int MUL_LAT = 3,
  parameter int ZERO_REG = 31,
  localparam int SEL_W = $clog2(FWD_STAGES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic             id_rs1_used,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_wr,
  input  logic             id_is_load,
  input  logic             id_is_mul,
  input  logic             id_sets_flags,
  input  logic [3:0]       ex_flags_in,
  output logic [SEL_W-1:0] fwd_sel1,
  output logic [SEL_W-1:0] fwd_sel2,
  output logic             stall,
  output logic             bubble,
  output logic             mul_busy,
  output logic [3:0]       flags_out
);
  localparam int CW = $clog2(MUL_LAT) + 1;
  localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);
  logic [FWD_STAGES:1] st_v, m1, m2;
  logic [REG_W-1:0] st_rd [1:FWD_STAGES];
  logic ld1, sf1, ok1, ok2, luse;
  logic [CW-1:0] mul_cnt;
  logic [3:0] flags_q;
  assign ok1 = id_rs1_used && id_rs1 != ZR;
  assign ok2 = id_rs2_used && id_rs2 != ZR;
  // a load sitting in EX has no result yet, so it is never a forwarding source
  for (genvar k = 1; k <= FWD_STAGES; k++) begin : g_match
    assign m1[k] = ok1 && st_v[k] && st_rd[k] == id_rs1 && !(k == 1 && ld1);
    assign m2[k] = ok2 && st_v[k] && st_rd[k] == id_rs2 && !(k == 1 && ld1);
  end
  always_comb begin
    fwd_sel1 = '0;
    fwd_sel2 = '0;
    for (int i = FWD_STAGES; i >= 1; i--) begin
      fwd_sel1 = m1[i] ? SEL_W'(i) : fwd_sel1;
      fwd_sel2 = m2[i] ? SEL_W'(i) : fwd_sel2;
    end
  end
  assign mul_busy = mul_cnt != '0;
  assign luse = !mul_busy && id_valid && st_v[1] && ld1 &&
                ((ok1 && st_rd[1] == id_rs1) || (ok2 && st_rd[1] == id_rs2));
  assign stall = mul_busy || luse;
  assign bubble = luse;
  assign flags_out = sf1 ? ex_flags_in : flags_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_v <= '0;
      for (int i = 1; i <= FWD_STAGES; i++) st_rd[i] <= '0;
      ld1 <= 1'b0;
      sf1 <= 1'b0;
      mul_cnt <= '0;
      flags_q <= '0;
    end else if (mul_busy) begin
      mul_cnt <= mul_cnt - CW'(1);
    end else begin
      flags_q <= sf1 ? ex_flags_in : flags_q;
      for (int i = FWD_STAGES; i >= 2; i--) begin
        st_v[i] <= st_v[i-1];
        st_rd[i] <= st_rd[i-1];
      end
      st_v[1] <= !luse && id_valid && id_wr && id_rd != ZR;
      st_rd[1] <= id_rd;
      ld1 <= !luse && id_is_load;
      sf1 <= !luse && id_valid && id_sets_flags;
      mul_cnt <= (!luse && id_valid && id_is_mul) ? CW'(MUL_LAT - 1) : '0;
    end
  end
endmodule
